// File: rtl/logic_gates_pipe_if.sv
// logic_gates_pipe_if: operand/result handshake bundle for logic_gates_pipe.
// master = producer/consumer side, slave = the pipeline itself.
interface logic_gates_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             zero;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, y, zero
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, y, zero
   );
endinterface

// File: rtl/logic_gates_pipe.sv
// logic_gates_pipe: eight-op bitwise logic unit behind a STAGES-deep
// valid/ready pipeline. Optional reductions: LOGIC_GATES_PIPE_REDUCE_EN.
module logic_gates_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   logic_gates_pipe_if.slave  bus,
`ifdef LOGIC_GATES_PIPE_REDUCE_EN
   output logic               red_and,
   output logic               red_or,
   output logic               red_xor,
`endif
   output logic [CNT_W-1:0]   op_count
);

   logic                          advance;
   logic                          accept;
   logic [WIDTH-1:0]              res;
   logic [STAGES-1:0]             vld;
   logic [STAGES-1:0][WIDTH-1:0]  dat;
   logic                          last_v_n;
   logic [WIDTH-1:0]              last_d_n;
   logic                          zero_q;

   // The whole pipe moves together unless the last stage is stuck.
   assign advance       = !vld[STAGES-1] || bus.out_ready;
   assign accept        = bus.in_valid && advance;
   assign bus.in_ready  = advance;
   assign bus.out_valid = vld[STAGES-1];
   assign bus.y         = dat[STAGES-1];
   assign bus.zero      = zero_q;

   // Stage-0 operation decode.
   always_comb begin
      res = '0;
      unique case (bus.op)
         3'd0: res = bus.a & bus.b;
         3'd1: res = bus.a | bus.b;
         3'd2: res = ~(bus.a & bus.b);
         3'd3: res = ~(bus.a | bus.b);
         3'd4: res = bus.a ^ bus.b;
         3'd5: res = ~(bus.a ^ bus.b);
         3'd6: res = ~bus.a;
         3'd7: res = bus.a;
         default: res = '0;
      endcase
   end

   generate
      if (STAGES == 1) begin : g_one
         assign last_v_n = bus.in_valid;
         assign last_d_n = res;

         // Single stage: load straight from the decoder.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld <= '0;
               dat <= '0;
            end else if (advance) begin
               vld <= bus.in_valid;
               dat <= res;
            end
         end
      end else begin : g_many
         assign last_v_n = vld[STAGES-2];
         assign last_d_n = dat[STAGES-2];

         // Shift register of valid bits and results; bubbles are kept.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld <= '0;
               dat <= '0;
            end else if (advance) begin
               vld <= {vld[STAGES-2:0], bus.in_valid};
               dat <= {dat[STAGES-2:0], res};
            end
         end
      end
   endgenerate

   // Flags computed from what enters the last stage, gated by its valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q <= 1'b0;
      end else if (advance) begin
         zero_q <= last_v_n && (last_d_n == '0);
      end
   end

`ifdef LOGIC_GATES_PIPE_REDUCE_EN
   // Reductions ride with y and obey the same hold rule.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         red_and <= 1'b0;
         red_or  <= 1'b0;
         red_xor <= 1'b0;
      end else if (advance) begin
         red_and <= last_v_n && (&last_d_n);
         red_or  <= last_v_n && (|last_d_n);
         red_xor <= last_v_n && (^last_d_n);
      end
   end
`endif

   // Accepted-beat counter, wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count <= '0;
      end else if (accept) begin
         op_count <= op_count + 1'b1;
      end
   end

endmodule

// File: doc/logic_gates_pipe.md
Name: logic_gates_pipe

Overview:
- Parametrised, pipelined successor to the two-input gate block.
- Applies one of eight bitwise logic ops to WIDTH-bit operands a and b, selected per transaction by op.
- Results leave through a STAGES-deep registered pipeline with valid/ready handshakes on both sides.
- Also provides a zero flag and a count of accepted transactions.
- Sits between operand producers and any registered consumer in the logic datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- STAGES, 2, pipeline depth, i.e. latency in cycles (1..4).
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  operation select.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- y  output  WIDTH  result.
- zero  output  1  high when y == 0 (qualified by out_valid).
- op_count  output  CNT_W  number of accepted input beats.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst asserted (asynchronous, active-high) clears every stage valid bit, y, zero and op_count to 0 immediately.
  - In-flight beats are discarded and not replayed.
  - Pipeline data registers other than y are don't-care after reset.
- op encoding, applied bitwise across WIDTH bits:
  - 0 AND
  - 1 OR
  - 2 NAND
  - 3 NOR
  - 4 XOR
  - 5 XNOR
  - 6 NOT a (b ignored)
  - 7 PASS a
- Result is computed combinationally at stage 0 input and registered into stage 1.
- Stages 2..STAGES are pure delay.
- Stall rule: advance = !out_valid || out_ready, where out_valid = valid of the last stage.
  - in_ready = advance. This is combinational, from out_ready and the last-stage valid only.
  - When advance=1, all stages shift on the clock edge and stage 1 loads valid = in_valid.
  - When advance=0, every stage holds. y, zero and out_valid stay stable while out_valid=1 && out_ready=0.
- Accept = in_valid && in_ready. Transfer = out_valid && out_ready.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 when there are no stalls. It is visible in the cycle following edge N+STAGES-1.
- Bubbles (in_valid=0 while advancing) propagate as invalid stages. They are not collapsed.
- Throughput: one beat per cycle when out_ready is held at 1.
- zero:
  - Registered alongside y in the last stage. Equals (y == 0).
  - Is 0 whenever out_valid=0.
- op_count:
  - Increments by 1 on every accept.
  - Wraps from 2^CNT_W-1 to 0.
  - Not affected by stalls or output transfers.
- Simultaneous accept and transfer in the same cycle is legal and required for full throughput.
- in_valid must stay asserted, with a, b and op stable, until accepted. The block does not check this.
- Changes to op while in_ready=0 have no effect.

Optional Feature:
- Macro: LOGIC_GATES_PIPE_REDUCE_EN.
- When defined, add three outputs, each 1 bit:
  - red_and = &y
  - red_or = |y
  - red_xor = ^y
- The reduction outputs are registered in the last stage with y, follow the same stall and hold rules, and reset to 0.
- They are forced to 0 while out_valid=0.
- When not defined, these ports and their logic are absent. All other behaviour is identical.

Test Plan (WIDTH=8, STAGES=2, CNT_W=16):
- Reset: assert rst mid-stream with 2 beats in flight -> out_valid, y, zero and op_count go to 0 immediately. After release, no stale result appears.
- Op sweep: a=0xF0, b=0x3C, op=0..7 back-to-back with out_ready=1 -> y = 0x30, 0xFC, 0xCF, 0x03, 0xCC, 0x33, 0x0F, 0xF0 on consecutive cycles. The first result is valid 2 cycles after its accept.
- Zero flag: op=2 (NAND), a=0xFF, b=0xFF -> y=0x00, zero=1. Then op=4 (XOR), a=0xAA, b=0xFF -> y=0x55, zero=0.
- Backpressure: stream 4 beats with out_ready low for 3 cycles while the first beat is valid:
  - y and out_valid are held stable.
  - in_ready=0 during the stall.
  - All 4 results arrive in order, none lost or duplicated.
  - op_count=4.
- Counter wrap: with CNT_W=4, accept 17 beats -> op_count reads 1.
- REDUCE_EN build: op=7 (PASS), a=0x07 -> red_and=0, red_or=1, red_xor=1. Then a=0xFF -> 1, 1, 0.
